// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the AXI4-Lite master adapter.
//
// Contents:
//   state_t          - adapter FSM states (IDLE, WRITE, WAIT_B, READ, WAIT_R)
//   RESP_*           - AXI response encodings
//   BURST_INCR       - burst type driven on aw_burst / ar_burst
//   size_enc()       - AXI size encoding (log2 of bytes per beat) for a data width
package axi_lite_master_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WAIT_B = 3'd2,
        READ   = 3'd3,
        WAIT_R = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Only 32 and 64 bit buses are supported; other widths fall back to the
    // 32 bit encoding.
    function automatic logic [2:0] size_enc(input int unsigned data_width);
        case (data_width)
            64:      return 3'd3;
            32:      return 3'd2;
            default: return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4-Lite capable bus interface (full AXI4 address-channel fields, no user
// signals). Master drives aw/w/ar and b_ready/r_ready, slave drives the rest.
//
// Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH.
// Modports:   Master, Slave.
interface AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_lite_master_adapter.sv
// AXI4-Lite master adapter: turns a single-outstanding req/gnt/rvalid port
// into AXI4-Lite single-beat reads and writes.
//
// Optional build macro: AXI_LITE_MASTER_ID_CHECK_EN
//   defined   - b_id / r_id are compared against AXI_ID; a mismatch forces
//               err_o with the completion pulse (plus a simulation $error).
//   undefined - response IDs are ignored.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i, we_i        request valid (held until gnt_o) and write select
//   addr_i, wdata_i    byte address and write data
//   be_i               byte enables, forwarded to w_strb
//   gnt_o              request accepted (req_i while IDLE)
//   rvalid_o           one-cycle completion pulse
//   rdata_o            read data, updated on reads only, held otherwise
//   err_o              response was not OKAY, valid with rvalid_o
//   dbg_state          current FSM state, for observation only
//   master             AXI_BUS master port
//
// Handshake rule on every AXI channel: a transfer happens on the rising edge
// where valid && ready. Valids are driven from registered state only, never
// from a ready, and address/data/strobe come from registers that do not
// change while a valid is pending.
module axi_lite_master_adapter
    import axi_lite_master_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output state_t                      dbg_state,
    AXI_BUS.Master                      master
);

    state_t                      state_q, state_d;
    logic                        aw_pend_q, aw_pend_d;
    logic                        w_pend_q, w_pend_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] be_q;
    logic                        rvalid_q;
    logic                        err_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;

    logic aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic id_err_b, id_err_r;

    assign gnt_o = req_i && (state_q == IDLE);

    assign aw_hs = aw_valid && master.aw_ready;
    assign w_hs  = w_valid  && master.w_ready;
    assign b_hs  = b_ready  && master.b_valid;
    assign ar_hs = ar_valid && master.ar_ready;
    assign r_hs  = r_ready  && master.r_valid;

`ifdef AXI_LITE_MASTER_ID_CHECK_EN
    assign id_err_b = (master.b_id != AXI_ID_WIDTH'(AXI_ID));
    assign id_err_r = (master.r_id != AXI_ID_WIDTH'(AXI_ID));
`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (b_hs && id_err_b) $error("axi_lite_master_adapter: unexpected b_id %0h", master.b_id);
        if (r_hs && id_err_r) $error("axi_lite_master_adapter: unexpected r_id %0h", master.r_id);
    end
`endif
`else
    assign id_err_b = 1'b0;
    assign id_err_r = 1'b0;
`endif

    // Response fields that carry no information for a single-beat,
    // single-ID master.
    logic unused_resp_fields;
    assign unused_resp_fields = ^{master.r_last, master.b_id, master.r_id};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_o) begin
                    if (we_i) begin
                        state_d   = WRITE;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                aw_valid = aw_pend_q;
                w_valid  = w_pend_q;
                // The two channels complete independently; leave as soon as
                // both are done, including when the last one finishes now.
                if (aw_hs) aw_pend_d = 1'b0;
                if (w_hs)  w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) state_d = WAIT_B;
            end
            WAIT_B: begin
                b_ready = 1'b1;
                if (b_hs) state_d = IDLE;
            end
            READ: begin
                ar_valid = 1'b1;
                if (ar_hs) state_d = WAIT_R;
            end
            WAIT_R: begin
                r_ready = 1'b1;
                if (r_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

    // ------------------------------------------------- request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (gnt_o) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
        end
    end

    // ------------------------------------------------ completion outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= b_hs || r_hs;
            if (b_hs) begin
                err_q <= (master.b_resp != RESP_OKAY) || id_err_b;
            end else if (r_hs) begin
                err_q <= (master.r_resp != RESP_OKAY) || id_err_r;
            end else begin
                err_q <= 1'b0;
            end
            if (r_hs) rdata_q <= master.r_data;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

    // ------------------------------------------------------ AXI outputs
    assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.aw_addr   = addr_q;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = size_enc(AXI_DATA_WIDTH);
    assign master.aw_burst  = BURST_INCR;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_valid  = aw_valid;

    assign master.w_data    = wdata_q;
    assign master.w_strb    = be_q;
    assign master.w_last    = 1'b1;
    assign master.w_valid   = w_valid;

    assign master.b_ready   = b_ready;

    assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.ar_addr   = addr_q;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = size_enc(AXI_DATA_WIDTH);
    assign master.ar_burst  = BURST_INCR;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_valid  = ar_valid;

    assign master.r_ready   = r_ready;

endmodule
